ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute-stage consumer of the ID/EX pipeline bundle in the 5-stage MIPS pipeline. It forwards operands, decodes ALU control, and computes the ALU result. It registers the result and control into the EX/MEM bundle. A multi-cycle multiply stalls upstream through stall_o, so ID/EX must hold its contents while stall_o=1.

Parameters:
MUL_CYCLES, 4, total EX occupancy of a mul in cycles; legal 1..16; 1 means no stall

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  synchronous, active-low reset
RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i  in  1 each  ID/EX control
ALUOp_i  in  2  ID/EX ALU op class
RSdata_i, RTdata_i, immediate_i  in  32 each  ID/EX data; funct = immediate_i[5:0]
RSaddr_i, RTaddr_i, RDaddr_i  in  5 each  ID/EX register addresses
EXMEM_RegWrite_i  in  1  / EXMEM_RDaddr_i  in  5 / EXMEM_data_i  in  32  forward source 1
MEMWB_RegWrite_i  in  1  / MEMWB_RDaddr_i  in  5 / MEMWB_data_i  in  32  forward source 2
stall_o  out  1  combinational; hold PC, IF/ID and ID/EX this cycle
MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o  out  1 each  registered EX/MEM control
ALUresult_o  out  32  registered result
RTdata_o  out  32  registered store data (post-forwarding RT)
WBaddr_o  out  5  registered destination (RDaddr_i if RegDst_i, else RTaddr_i)

Behaviour:
- Reset (rst_i=0 at posedge): all registered outputs 0; FSM to IDLE; counter 0. stall_o is 0 while in reset state.
- Forwarding per operand (RS, RT): if EXMEM_RegWrite_i, EXMEM_RDaddr_i!=0 and the address matches, use EXMEM_data_i. Else if the MEM/WB equivalent matches, use MEMWB_data_i. Else use the ID/EX data. EX/MEM takes priority.
- Operand B = ALUSrc_i ? immediate_i : forwarded RT.
- ALU function:
  - ALUOp 00: add.
  - ALUOp 01: sub (A-B).
  - ALUOp 11: and.
  - ALUOp 10: by funct. 100000 add, 100010 sub, 100100 and, 100101 or, 011000 mul (low 32 bits of the product). Any other funct gives result 0 with controls passed unchanged.
- Arithmetic is 32-bit, wraps modulo 2^32, and sets no overflow flag.
- Non-mul latency: 1 cycle. The EX/MEM outputs load on the next posedge; stall_o=0.
- FSM states: IDLE, BUSY.
  - IDLE, mul presented, MUL_CYCLES>1: assert stall_o; latch the forwarded A/B; cnt<=MUL_CYCLES-2; go to BUSY; load a bubble into EX/MEM.
  - BUSY, cnt!=0: stall_o=1; cnt decrements; load a bubble.
  - BUSY, cnt==0: stall_o=0; load the product of the latched operands with the mul's controls and WBaddr; go to IDLE.
  - MUL_CYCLES=1: the mul behaves like any 1-cycle op.
- stall_o is high for exactly MUL_CYCLES-1 consecutive cycles per mul.
- Bubble: MemRead_o, MemWrite_o, MemtoReg_o and RegWrite_o all 0; ALUresult_o, RTdata_o and WBaddr_o all 0.
- In BUSY, ID/EX inputs are ignored except for control passthrough in the final cycle. Operands come from the latch, because forwarding sources change while bubbles drain.
- Reset mid-mul: IDLE and zeroed outputs on that edge; the product is never written back.
- A back-to-back mul after completion starts a new sequence from IDLE.

Optional Feature:
EX_FORWARD_EN
- Defined: forwarding as above.
- Undefined: operand A = RSdata_i and forwarded RT = RTdata_i. The EXMEM_* and MEMWB_* inputs stay on the port list but are ignored. Software or the hazard unit handles dependencies.

Test Plan:
- Reset: rst_i=0 for 2 cycles with random inputs -> all outputs 0, stall_o=0.
- R-add: RS=5, RT=7, ALUOp=10, funct=100000, RegDst=1, RD=3, RegWrite=1 -> next cycle ALUresult_o=12, WBaddr_o=3, RegWrite_o=1.
- lw: ALUSrc=1, ALUOp=00, RS=0x100, imm=0xFFFFFFFC, RT=9, RegDst=0, MemRead=1 -> ALUresult_o=0xFC, WBaddr_o=9, MemRead_o=1.
- Forwarding (EX_FORWARD_EN): RSaddr=3, RSdata=1, EXMEM rd=3 data 0x10, MEMWB rd=3 data 0x20, add with RT=0 -> 0x10. With EXMEM_RegWrite=0 -> 0x20. With the address set to 0 in both -> 1.
- mul, MUL_CYCLES=4: RS=6, RT=7, funct=011000 -> stall_o=1 for 3 cycles with EX/MEM bubbles; the 4th edge gives ALUresult_o=42 and RegWrite_o=1. MUL_CYCLES=1 -> 42 after 1 cycle with no stall.
- Reset mid-mul: rst_i=0 on the 2nd stall cycle -> stall_o=0 and zeroed outputs the following cycle; 42 never appears.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Forwards operands, decodes ALU control, computes the ALU result and
// registers it with the EX/MEM control bundle. A mul occupies EX for
// MUL_CYCLES cycles and holds the upstream stages through stall_o.
// Optional feature macro: EX_FORWARD_EN (operand forwarding from EX/MEM
// and MEM/WB). Without it the ID/EX operands are used as-is.
module ex_stage #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] immediate_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_RDaddr_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RDaddr_i,
  input  logic [31:0] MEMWB_data_i,
  output logic        stall_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] RTdata_o,
  output logic [4:0]  WBaddr_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_MUL = 6'b011000;

  // A single-cycle mul needs no sequencing at all.
  localparam logic       MUL_MULTI = (MUL_CYCLES > 1) ? 1'b1 : 1'b0;
  // Stall cycles after the first one; the IDLE cycle already counts as one.
  localparam logic [3:0] CNT_INIT  = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t      state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic [31:0] lat_a_r, lat_b_r, lat_rt_r;
  logic        load_lat_s;
  logic        stall_s;

  logic [31:0] op_a_s, fwd_rt_s, op_b_s, alu_res_s, mul_res_s;
  logic [5:0]  funct_s;
  logic        is_mul_s;
  logic [4:0]  wb_addr_s;

  logic        nxt_mem_read_s, nxt_mem_write_s, nxt_mem_to_reg_s, nxt_reg_write_s;
  logic [31:0] nxt_result_s, nxt_rt_s;
  logic [4:0]  nxt_wb_addr_s;

`ifdef EX_FORWARD_EN
  // Newest producer wins: EX/MEM before MEM/WB; register 0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] data,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    logic [31:0] sel;
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == addr)) begin
      sel = ex_data;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == addr)) begin
      sel = wb_data;
    end else begin
      sel = data;
    end
    return sel;
  endfunction

  assign op_a_s   = fwd_sel(RSaddr_i, RSdata_i, EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
                            MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i);
  assign fwd_rt_s = fwd_sel(RTaddr_i, RTdata_i, EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
                            MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i);
`else
  // Dependencies are resolved elsewhere; forward-source ports are sunk here.
  logic unused_fwd_s;
  assign unused_fwd_s = ^{EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
                          MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i, RSaddr_i};
  assign op_a_s   = RSdata_i;
  assign fwd_rt_s = RTdata_i;
`endif

  assign op_b_s    = ALUSrc_i ? immediate_i : fwd_rt_s;
  assign funct_s   = immediate_i[5:0];
  assign is_mul_s  = (ALUOp_i == 2'b10) && (funct_s == F_MUL);
  assign wb_addr_s = RegDst_i ? RDaddr_i : RTaddr_i;
  assign mul_res_s = lat_a_r * lat_b_r;

  // Single-cycle ALU: op class decode, then funct decode for R-type.
  always_comb begin
    alu_res_s = 32'd0;
    case (ALUOp_i)
      2'b00:   alu_res_s = op_a_s + op_b_s;
      2'b01:   alu_res_s = op_a_s - op_b_s;
      2'b11:   alu_res_s = op_a_s & op_b_s;
      2'b10: begin
        case (funct_s)
          F_ADD:   alu_res_s = op_a_s + op_b_s;
          F_SUB:   alu_res_s = op_a_s - op_b_s;
          F_AND:   alu_res_s = op_a_s & op_b_s;
          F_OR:    alu_res_s = op_a_s | op_b_s;
          F_MUL:   alu_res_s = op_a_s * op_b_s;
          default: alu_res_s = 32'd0;
        endcase
      end
      default: alu_res_s = 32'd0;
    endcase
  end

  // Mul sequencer next state, stall request and next EX/MEM contents.
  always_comb begin
    state_n           = state_r;
    cnt_n             = cnt_r;
    stall_s           = 1'b0;
    load_lat_s        = 1'b0;
    nxt_mem_read_s    = MemRead_i;
    nxt_mem_write_s   = MemWrite_i;
    nxt_mem_to_reg_s  = MemtoReg_i;
    nxt_reg_write_s   = RegWrite_i;
    nxt_result_s      = alu_res_s;
    nxt_rt_s          = fwd_rt_s;
    nxt_wb_addr_s     = wb_addr_s;
    case (state_r)
      IDLE: begin
        if (is_mul_s && MUL_MULTI) begin
          stall_s          = 1'b1;
          load_lat_s       = 1'b1;
          cnt_n            = CNT_INIT;
          state_n          = BUSY;
          nxt_mem_read_s   = 1'b0;
          nxt_mem_write_s  = 1'b0;
          nxt_mem_to_reg_s = 1'b0;
          nxt_reg_write_s  = 1'b0;
          nxt_result_s     = 32'd0;
          nxt_rt_s         = 32'd0;
          nxt_wb_addr_s    = 5'd0;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          stall_s          = 1'b1;
          cnt_n            = cnt_r - 4'd1;
          nxt_mem_read_s   = 1'b0;
          nxt_mem_write_s  = 1'b0;
          nxt_mem_to_reg_s = 1'b0;
          nxt_reg_write_s  = 1'b0;
          nxt_result_s     = 32'd0;
          nxt_rt_s         = 32'd0;
          nxt_wb_addr_s    = 5'd0;
        end else begin
          // Final cycle: operands come from the latch, controls from ID/EX.
          state_n      = IDLE;
          nxt_result_s = mul_res_s;
          nxt_rt_s     = lat_rt_r;
        end
      end
      default: begin
        state_n          = IDLE;
        cnt_n            = 4'd0;
        nxt_mem_read_s   = 1'b0;
        nxt_mem_write_s  = 1'b0;
        nxt_mem_to_reg_s = 1'b0;
        nxt_reg_write_s  = 1'b0;
        nxt_result_s     = 32'd0;
        nxt_rt_s         = 32'd0;
        nxt_wb_addr_s    = 5'd0;
      end
    endcase
  end

  // No stall request while the stage is held in reset.
  assign stall_o = stall_s & rst_i;

  // Sequencer state and EX/MEM pipeline register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      MemRead_o   <= 1'b0;
      MemWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      RegWrite_o  <= 1'b0;
      ALUresult_o <= 32'd0;
      RTdata_o    <= 32'd0;
      WBaddr_o    <= 5'd0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      MemRead_o   <= nxt_mem_read_s;
      MemWrite_o  <= nxt_mem_write_s;
      MemtoReg_o  <= nxt_mem_to_reg_s;
      RegWrite_o  <= nxt_reg_write_s;
      ALUresult_o <= nxt_result_s;
      RTdata_o    <= nxt_rt_s;
      WBaddr_o    <= nxt_wb_addr_s;
    end
  end

  // Capture mul operands at start, since forwarding sources move while stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lat_a_r  <= 32'd0;
      lat_b_r  <= 32'd0;
      lat_rt_r <= 32'd0;
    end else if (load_lat_s) begin
      lat_a_r  <= op_a_s;
      lat_b_r  <= op_b_s;
      lat_rt_r <= fwd_rt_s;
    end else begin
      lat_a_r  <= lat_a_r;
      lat_b_r  <= lat_b_r;
      lat_rt_r <= lat_rt_r;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage. Two instances
// share the stimulus: MUL_CYCLES=4 (main) and MUL_CYCLES=1 (no stall).
module tb_ex_stage;

  localparam int MC0 = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RSdata_i, RTdata_i, immediate_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic [4:0]  EXMEM_RDaddr_i, MEMWB_RDaddr_i;
  logic [31:0] EXMEM_data_i, MEMWB_data_i;

  logic        stall_o0, MemRead_o0, MemWrite_o0, MemtoReg_o0, RegWrite_o0;
  logic [31:0] ALUresult_o0, RTdata_o0;
  logic [4:0]  WBaddr_o0;
  logic        stall_o1, MemRead_o1, MemWrite_o1, MemtoReg_o1, RegWrite_o1;
  logic [31:0] ALUresult_o1, RTdata_o1;
  logic [4:0]  WBaddr_o1;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic [4:0]  wb;
    logic [31:0] rt;
    logic [31:0] res;
  } exo_t;

  int          errors = 0;
  int          checks = 0;
  int          k = 0;
  int          nstall;
  logic [31:0] sv_prod, sv_rt;
  logic        exp_stall = 1'b0;
  logic        obs_stall;
  exo_t        exp0, exp1;

  always #5 clk = ~clk;

  ex_stage #(.MUL_CYCLES(MC0)) dut0 (
    .clk_i(clk), .rst_i(rst_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .immediate_i(immediate_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i), .EXMEM_data_i(EXMEM_data_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .stall_o(stall_o0), .MemRead_o(MemRead_o0), .MemWrite_o(MemWrite_o0), .MemtoReg_o(MemtoReg_o0),
    .RegWrite_o(RegWrite_o0), .ALUresult_o(ALUresult_o0), .RTdata_o(RTdata_o0), .WBaddr_o(WBaddr_o0)
  );

  ex_stage #(.MUL_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i),
    .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .immediate_i(immediate_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i), .EXMEM_data_i(EXMEM_data_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .stall_o(stall_o1), .MemRead_o(MemRead_o1), .MemWrite_o(MemWrite_o1), .MemtoReg_o(MemtoReg_o1),
    .RegWrite_o(RegWrite_o1), .ALUresult_o(ALUresult_o1), .RTdata_o(RTdata_o1), .WBaddr_o(WBaddr_o1)
  );

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand value a register read sees in EX, after any bypass.
  function automatic logic [31:0] fwd_val(input logic [4:0] addr, input logic [31:0] data);
`ifdef EX_FORWARD_EN
    if (EXMEM_RegWrite_i && EXMEM_RDaddr_i != 5'd0 && EXMEM_RDaddr_i == addr) return EXMEM_data_i;
    if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == addr) return MEMWB_data_i;
`endif
    return data;
  endfunction

  // One clock: predict, check stall before the edge, check EX/MEM after it.
  task automatic step();
    logic [31:0] a, b, rt, res;
    logic        mul;
    exo_t        comb;
    @(negedge clk);
    a   = fwd_val(RSaddr_i, RSdata_i);
    rt  = fwd_val(RTaddr_i, RTdata_i);
    b   = ALUSrc_i ? immediate_i : rt;
    mul = (ALUOp_i == 2'd2) && (immediate_i[5:0] == 6'd24);
    res = 32'd0;
    if (ALUOp_i == 2'd0) res = a + b;
    else if (ALUOp_i == 2'd1) res = a - b;
    else if (ALUOp_i == 2'd3) res = a & b;
    else if (immediate_i[5:0] == 6'd32) res = a + b;
    else if (immediate_i[5:0] == 6'd34) res = a - b;
    else if (immediate_i[5:0] == 6'd36) res = a & b;
    else if (immediate_i[5:0] == 6'd37) res = a | b;
    else if (mul) res = a * b;
    comb = '{MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i,
             (RegDst_i ? RDaddr_i : RTaddr_i), rt, res};
    if (!rst_i) begin
      exp_stall = 1'b0; exp0 = '0; exp1 = '0; k = 0;
    end else begin
      exp1 = comb;
      if (k == 0) begin
        if (mul && MC0 > 1) begin
          exp_stall = 1'b1; sv_prod = a * b; sv_rt = rt; k = MC0 - 1; exp0 = '0;
        end else begin
          exp_stall = 1'b0; exp0 = comb;
        end
      end else begin
        if (k > 1) begin
          exp_stall = 1'b1; exp0 = '0;
        end else begin
          exp_stall = 1'b0; exp0 = comb; exp0.res = sv_prod; exp0.rt = sv_rt;
        end
        k = k - 1;
      end
    end
    obs_stall = stall_o0;
    check("stall0", {72'd0, stall_o0}, {72'd0, exp_stall});
    check("stall1", {72'd0, stall_o1}, 73'd0);
    @(posedge clk);
    #1;
    check("exmem0", {MemRead_o0, MemWrite_o0, MemtoReg_o0, RegWrite_o0, WBaddr_o0, RTdata_o0, ALUresult_o0}, exp0);
    check("exmem1", {MemRead_o1, MemWrite_o1, MemtoReg_o1, RegWrite_o1, WBaddr_o1, RTdata_o1, ALUresult_o1}, exp1);
  endtask

  task automatic clear_all();
    {RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i} = 6'd0;
    ALUOp_i = 2'd0; RSdata_i = 32'd0; RTdata_i = 32'd0; immediate_i = 32'd0;
    RSaddr_i = 5'd0; RTaddr_i = 5'd0; RDaddr_i = 5'd0;
    EXMEM_RegWrite_i = 1'b0; EXMEM_RDaddr_i = 5'd0; EXMEM_data_i = 32'd0;
    MEMWB_RegWrite_i = 1'b0; MEMWB_RDaddr_i = 5'd0; MEMWB_data_i = 32'd0;
  endtask

  task automatic rand_fwd();
    EXMEM_RegWrite_i = 1'($urandom_range(0, 1));
    EXMEM_RDaddr_i   = 5'($urandom_range(0, 3));
    EXMEM_data_i     = $urandom();
    MEMWB_RegWrite_i = 1'($urandom_range(0, 1));
    MEMWB_RDaddr_i   = 5'($urandom_range(0, 3));
    MEMWB_data_i     = $urandom();
  endtask

  task automatic rand_idex();
    logic [31:0] imm;
    logic [5:0]  f;
    int          sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       f = 6'b100000;
      1:       f = 6'b100010;
      2:       f = 6'b100100;
      3:       f = 6'b100101;
      4:       f = 6'b011000;
      default: f = 6'($urandom());
    endcase
    imm = $urandom();
    imm[5:0] = f;
    immediate_i = imm;
    ALUOp_i  = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom());
    {RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i} = 6'($urandom());
    RSdata_i = $urandom(); RTdata_i = $urandom();
    RSaddr_i = 5'($urandom_range(0, 3)); RTaddr_i = 5'($urandom_range(0, 3));
    RDaddr_i = 5'($urandom());
  endtask

  initial begin
    // Reset with random inputs
    rst_i = 1'b0;
    rand_idex(); rand_fwd(); step();
    rand_idex(); rand_fwd(); step();
    rst_i = 1'b1;

    // R-type add
    clear_all();
    RSdata_i = 32'd5; RTdata_i = 32'd7; ALUOp_i = 2'd2; immediate_i = 32'h20;
    RegDst_i = 1'b1; RDaddr_i = 5'd3; RegWrite_i = 1'b1; RSaddr_i = 5'd1; RTaddr_i = 5'd2;
    step();
    check("radd_res", {41'd0, ALUresult_o0}, 73'd12);
    check("radd_wb", {68'd0, WBaddr_o0}, 73'd3);
    check("radd_rw", {72'd0, RegWrite_o0}, 73'd1);

    // lw address computation
    clear_all();
    ALUSrc_i = 1'b1; RSdata_i = 32'h100; immediate_i = 32'hFFFF_FFFC; RTaddr_i = 5'd9; MemRead_i = 1'b1;
    step();
    check("lw_res", {41'd0, ALUresult_o0}, 73'hFC);
    check("lw_wb", {68'd0, WBaddr_o0}, 73'd9);
    check("lw_mr", {72'd0, MemRead_o0}, 73'd1);

    // Forwarding priority
    clear_all();
    RSaddr_i = 5'd3; RSdata_i = 32'd1;
    EXMEM_RegWrite_i = 1'b1; EXMEM_RDaddr_i = 5'd3; EXMEM_data_i = 32'h10;
    MEMWB_RegWrite_i = 1'b1; MEMWB_RDaddr_i = 5'd3; MEMWB_data_i = 32'h20;
    step();
`ifdef EX_FORWARD_EN
    check("fwd_ex", {41'd0, ALUresult_o0}, 73'h10);
`else
    check("nofwd_ex", {41'd0, ALUresult_o0}, 73'h1);
`endif
    EXMEM_RegWrite_i = 1'b0;
    step();
`ifdef EX_FORWARD_EN
    check("fwd_wb", {41'd0, ALUresult_o0}, 73'h20);
`else
    check("nofwd_wb", {41'd0, ALUresult_o0}, 73'h1);
`endif
    EXMEM_RegWrite_i = 1'b1; RSaddr_i = 5'd0; EXMEM_RDaddr_i = 5'd0; MEMWB_RDaddr_i = 5'd0;
    step();
    check("fwd_zero", {41'd0, ALUresult_o0}, 73'h1);

    // mul with drifting forward sources while stalled
    clear_all();
    RSdata_i = 32'd6; RTdata_i = 32'd7; ALUOp_i = 2'd2; immediate_i = 32'h18;
    RegDst_i = 1'b1; RDaddr_i = 5'd5; RegWrite_i = 1'b1; RSaddr_i = 5'd1; RTaddr_i = 5'd2;
    nstall = 0;
    step();
    if (obs_stall) nstall++;
    check("mul1_res", {41'd0, ALUresult_o1}, 73'd42);
    for (int i = 0; i < MC0 - 1; i++) begin
      rand_fwd();
      step();
      if (obs_stall) nstall++;
    end
    check("mul_res", {41'd0, ALUresult_o0}, 73'd42);
    check("mul_rw", {72'd0, RegWrite_o0}, 73'd1);
    check("mul_nstall", 73'(nstall), 73'(MC0 - 1));

    // Reset on the second stall cycle
    clear_all();
    RSdata_i = 32'd6; RTdata_i = 32'd7; ALUOp_i = 2'd2; immediate_i = 32'h18;
    RegDst_i = 1'b1; RDaddr_i = 5'd5; RegWrite_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    check("rstmul_res", {41'd0, ALUresult_o0}, 73'd0);
    rst_i = 1'b1;
    clear_all();
    for (int i = 0; i < MC0; i++) begin
      step();
      check("rstmul_no42", {72'd0, ALUresult_o0 == 32'd42}, 73'd0);
    end

    // Random traffic; ID/EX holds while the model expects a stall
    for (int i = 0; i < 800; i++) begin
      if (!exp_stall) rand_idex();
      rand_fwd();
      rst_i = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
